// File: rtl/dport_pkg.sv
// Shared constants for the data-port merge arbiter.
package dport_pkg;
  localparam int DPORT_W     = 8;
  localparam int DPORT_DEPTH = 8;
  localparam int DPORT_CW    = $clog2(DPORT_DEPTH) + 1;
endpackage

// File: rtl/dport_fifo2w.sv
// Two-write / one-read circular buffer. Within a cycle din1 is older than din2.
// Writes that do not fit are dropped youngest-first, and drop is raised.
module dport_fifo2w
  import dport_pkg::*;
#(
  parameter int WIDTH = DPORT_W,
  parameter int DEPTH = DPORT_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr1,
  input  logic [WIDTH-1:0] din1,
  input  logic             wr2,
  input  logic [WIDTH-1:0] din2,
  input  logic             rd,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             pop;
  logic [CW-1:0]    free;
  logic [CW-1:0]    nreq;
  logic [1:0]       acc;

  // Accept logic: a same-cycle pop frees one slot for the incoming writes.
  always_comb begin
    pop  = (cnt != '0) & rd;
    free = CW'(DEPTH) - cnt + CW'(pop);
    nreq = CW'(wr1) + CW'(wr2);
    acc  = (nreq <= free) ? nreq[1:0] : free[1:0];
    drop = (nreq > free);
  end

  // Storage, pointers and occupancy. The first accepted byte goes to wptr and
  // is din1 when port 1 wrote, otherwise din2 took the single slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (acc != 2'd0) mem[wptr] <= wr1 ? din1 : din2;
      if (acc == 2'd2) mem[wptr + PW'(1)] <= din2;
      wptr <= wptr + PW'(acc);
      rptr <= rptr + PW'(pop);
      cnt  <= cnt + CW'(acc) - CW'(pop);
    end
  end

  assign out_valid = (cnt != '0);
  assign out_data  = mem[rptr];
  assign count     = cnt;

endmodule

// File: rtl/dport_merge_arbiter.sv
// Merges the two data-port write channels into one ordered byte stream, with
// core stall, sticky overflow and a done flag that waits for the buffer to drain.
module dport_merge_arbiter
  import dport_pkg::*;
#(
  parameter int WIDTH = DPORT_W,
  parameter int DEPTH = DPORT_DEPTH,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr1,
  input  logic [WIDTH-1:0] din1,
  input  logic             wr2,
  input  logic [WIDTH-1:0] din2,
  input  logic             sys_done,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             stall,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             done
);

  logic drop;
  logic done_seen;

  dport_fifo2w #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr1       (wr1),
    .din1      (din1),
    .wr2       (wr2),
    .din2      (din2),
    .rd        (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (count),
    .drop      (drop)
  );

  // Sticky status: overflow on any dropped byte, done_seen once the core retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      done_seen <= 1'b0;
    end else begin
      if (drop)     overflow  <= 1'b1;
      if (sys_done) done_seen <= 1'b1;
    end
  end

  // A dual write needs two slots, so stall while fewer than two are free.
  assign stall = ((CW'(DEPTH) - count) < CW'(2));
  assign done  = done_seen & (count == '0);

endmodule

// File: tb/tb_dport_merge_arbiter.sv
// Randomised bench for dport_merge_arbiter against a queue-based reference model.
module tb_dport_merge_arbiter;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr1, wr2, sys_done, out_ready;
  logic [W-1:0]  din1, din2;
  logic          out_valid, stall, overflow, done;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  logic [W-1:0] q[$];
  bit m_ovf      = 1'b0;
  bit m_seen     = 1'b0;
  bit m_data_zero = 1'b1;

  always #5 clk = ~clk;

  dport_merge_arbiter #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr1       (wr1),
    .din1      (din1),
    .wr2       (wr2),
    .din2      (din2),
    .sys_done  (sys_done),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .stall     (stall),
    .count     (count),
    .overflow  (overflow),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int sz = q.size();
    chk("out_valid", 32'(out_valid), 32'(sz != 0));
    chk("count",     32'(count),     32'(sz));
    chk("stall",     32'(stall),     32'((D - sz) < 2));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("done",      32'(done),      32'(m_seen && sz == 0));
    if (sz != 0)          chk("out_data",      32'(out_data), 32'(q[0]));
    else if (m_data_zero) chk("out_data_rst",  32'(out_data), 32'h0);
  endtask

  task automatic model_update(input bit w1, input logic [W-1:0] d1, input bit w2,
                              input logic [W-1:0] d2, input bit sd, input bit rdy, input bit r);
    int  free;
    bit  pop;
    logic [W-1:0] cand[$];
    if (r) begin
      q.delete();
      m_ovf = 0; m_seen = 0; m_data_zero = 1;
      return;
    end
    pop  = (q.size() != 0) && rdy;
    free = D - q.size() + (pop ? 1 : 0);
    if (pop) void'(q.pop_front());
    if (w1) cand.push_back(d1);
    if (w2) cand.push_back(d2);
    foreach (cand[i]) begin
      if (free > 0) begin
        q.push_back(cand[i]);
        free--;
        m_data_zero = 0;
      end else begin
        m_ovf = 1;
      end
    end
    if (sd) m_seen = 1;
  endtask

  // check the state produced by the previous edge, then drive the next cycle
  task automatic step(input bit w1, input logic [W-1:0] d1, input bit w2,
                      input logic [W-1:0] d2, input bit sd, input bit rdy, input bit r);
    @(negedge clk);
    check_outputs();
    wr1 = w1; din1 = d1; wr2 = w2; din2 = d2;
    sys_done = sd; out_ready = rdy; rst = r;
    model_update(w1, d1, w2, d2, sd, rdy, r);
  endtask

  initial begin
    rst = 1'b1; wr1 = 0; wr2 = 0; din1 = '0; din2 = '0; sys_done = 0; out_ready = 0;
    q.delete();
    repeat (2) @(posedge clk);
    step(0, 8'h00, 0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 8'h00, 0, 0, 0);

    // single write, sink ready
    step(1, 8'h11, 0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 8'h00, 0, 1, 0);

    // dual write ordering
    step(1, 8'hA1, 1, 8'hB2, 0, 1, 0);
    step(0, 8'h00, 0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 8'h00, 0, 1, 0);

    // fill with dual writes, then overflow while full, then full + pop + write
    for (int i = 0; i < 4; i++) step(1, 8'(8'h20 + 2*i), 1, 8'(8'h21 + 2*i), 0, 0, 0);
    step(0, 8'h00, 0, 8'h00, 0, 0, 0);
    step(1, 8'hC3, 1, 8'hD4, 0, 0, 0);
    step(0, 8'h00, 0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 8'(8'h30 + 2*i), 1, 8'(8'h31 + 2*i), 0, 0, 0);
    step(1, 8'hE5, 0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 8'h00, 0, 0, 0);

    // drain-then-done
    step(0, 8'h00, 0, 8'h00, 0, 0, 1);
    step(1, 8'h41, 1, 8'h42, 0, 0, 0);
    step(1, 8'h43, 0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 8'h00, 0, 0, 0);

    // write coincident with sys_done must be drained before done
    step(1, 8'h55, 0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 8'h00, 0, 0, 1);

    // randomised phases with varying sink back-pressure
    for (int ph = 0; ph < 8; ph++) begin
      int rdy_pct = (ph % 4) * 30 + 5;
      for (int c = 0; c < 250; c++) begin
        bit r  = ($urandom_range(0, 299) == 0);
        bit sd = ($urandom_range(0, 99) == 0);
        step($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1), 8'($urandom),
             sd, ($urandom_range(0, 99) < rdy_pct), r);
      end
    end

    step(0, 8'h00, 0, 8'h00, 0, 1, 0);
    @(negedge clk);
    check_outputs();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
